accelerator_standard_transformer_transpose: RTL and testbench
=============================================================

Name: accelerator_standard_transformer_transpose

Overview:
- Matrix stream reader/re-emitter for the standard transformer accelerator.
- Consumes a row-major matrix stream (I/J enable strobes) produced by upstream transformer stages.
- Buffers the matrix, then emits it transposed as a row-major stream using the same strobe convention.
- Feeds the K^T operand of scaled dot-product attention.

Parameters:
- DATA_SIZE, 64, element width in bits
- CONTROL_SIZE, 64, width of size inputs
- MAX_I, 8, max rows of input matrix
- MAX_J, 8, max columns of input matrix

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous reset, active-high
- START  in  1  begin a transfer; sampled only in IDLE
- READY  out  1  one-cycle pulse when transfer complete
- SIZE_I_IN  in  CONTROL_SIZE  input rows
- SIZE_J_IN  in  CONTROL_SIZE  input columns
- DATA_IN_I_ENABLE  in  1  marks first element of an input row; informational
- DATA_IN_J_ENABLE  in  1  input element valid
- DATA_IN  in  DATA_SIZE  input element
- DATA_OUT_I_ENABLE  out  1  marks first element of an output row
- DATA_OUT_J_ENABLE  out  1  output element valid
- DATA_OUT  out  DATA_SIZE  output element

Behaviour:
- Reset: state IDLE; READY, DATA_OUT_I_ENABLE and DATA_OUT_J_ENABLE = 0; DATA_OUT = 0; counters = 0. Buffer contents are not cleared.
- Buffer: MAX_I*MAX_J words; address = i*MAX_J + j.
- FSM states: IDLE, LOAD, EMIT, DONE.
- IDLE:
  - START=1 latches SIZE_I_IN and SIZE_J_IN and clears i and j.
  - If either size is 0: go to DONE.
  - Otherwise: go to LOAD.
- LOAD:
  - Each cycle with DATA_IN_J_ENABLE=1 writes DATA_IN at (i,j), then j++.
  - When j reaches SIZE_J-1, j wraps to 0 and i++.
  - Addressing is counter-driven only; DATA_IN_I_ENABLE does not affect it.
  - Cycles with DATA_IN_J_ENABLE=0 do nothing, so gaps of any length are allowed.
  - Accepting element SIZE_I*SIZE_J moves to EMIT on the next cycle.
- EMIT:
  - Outer loop is j from 0 to SIZE_J-1; inner loop is i from 0 to SIZE_I-1.
  - One element per cycle; no backpressure.
  - Outputs are registered: DATA_OUT = buf(i,j), DATA_OUT_J_ENABLE = 1, DATA_OUT_I_ENABLE = 1 when i==0.
  - After the last element, go to DONE.
- DONE: READY = 1 for exactly one cycle, enables = 0, then IDLE.
- Latency:
  - Last input accepted at cycle t.
  - First output valid at t+2.
  - Last output valid at t+1+SIZE_I*SIZE_J.
  - READY at t+2+SIZE_I*SIZE_J.
- DATA_OUT holds its last value when the enables are 0.
- START outside IDLE is ignored.
- DATA_IN_J_ENABLE outside LOAD is ignored.
- START in the READY cycle is ignored; START in the following IDLE cycle is accepted.
- RST=1 in any state returns to IDLE on the next edge and applies all reset values. The next transfer is fully independent.
- Sizes larger than MAX_I or MAX_J are clamped to MAX_I or MAX_J at latch time (no macro).

Optional Feature:
- Macro: ACCELERATOR_TRANSPOSE_SIZE_CHECK_EN.
- When defined:
  - Adds port ERROR (out, 1, reset 0).
  - If a latched size is greater than its MAX, skip LOAD and EMIT and go to DONE. READY pulses with ERROR=1 in the same cycle. ERROR stays 1 until the next accepted START or RST.
  - Zero sizes do not set ERROR.
- When undefined: no ERROR port; oversize is handled by clamping as above.

Test Plan:
- 2x3 input [1 2 3; 4 5 6] on back-to-back cycles -> output stream 1,4,2,5,3,6; DATA_OUT_I_ENABLE on 1, 2 and 3; READY at t+8.
- Same matrix with 2-cycle gaps between inputs -> identical output; first output arrives 2 cycles after the 6th accepted input.
- SIZE_I_IN=0, SIZE_J_IN=4, START -> READY two cycles after START; no DATA_OUT_J_ENABLE pulse.
- 3x3 transfer with RST asserted during the 4th EMIT cycle -> enables 0 on the next cycle; a new 1x2 transfer [7 8] then outputs 7 and 8, each with DATA_OUT_I_ENABLE=1.
- START pulsed during LOAD and EMIT of a 2x2 transfer -> ignored; exactly 4 outputs and one READY.
- With the macro, SIZE_I_IN=9 (MAX_I=8) -> READY and ERROR both 1 two cycles after START; no outputs; ERROR cleared by the next valid START.

Source files
------------

// File: rtl/accelerator_standard_transformer_transpose.sv
// Buffers a row-major matrix stream and re-emits it transposed, using the same I/J strobe convention.
// Optional define ACCELERATOR_TRANSPOSE_SIZE_CHECK_EN adds an ERROR output and rejects oversize transfers.
module accelerator_standard_transformer_transpose #(
  parameter int unsigned DATA_SIZE    = 64,
  parameter int unsigned CONTROL_SIZE = 64,
  parameter int unsigned MAX_I        = 8,
  parameter int unsigned MAX_J        = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  output logic                    READY,
  input  logic [CONTROL_SIZE-1:0] SIZE_I_IN,
  input  logic [CONTROL_SIZE-1:0] SIZE_J_IN,
  input  logic                    DATA_IN_I_ENABLE,
  input  logic                    DATA_IN_J_ENABLE,
  input  logic [DATA_SIZE-1:0]    DATA_IN,
  output logic                    DATA_OUT_I_ENABLE,
  output logic                    DATA_OUT_J_ENABLE,
`ifdef ACCELERATOR_TRANSPOSE_SIZE_CHECK_EN
  output logic                    ERROR,
`endif
  output logic [DATA_SIZE-1:0]    DATA_OUT
);

  localparam int unsigned DEPTH = MAX_I * MAX_J;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned MAX_D = (MAX_I > MAX_J) ? MAX_I : MAX_J;
  localparam int unsigned SW    = $clog2(MAX_D + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t               state;
  logic [SW-1:0]        size_i;
  logic [SW-1:0]        size_j;
  logic [SW-1:0]        cnt_i;
  logic [SW-1:0]        cnt_j;
  logic [DATA_SIZE-1:0] mem [DEPTH];

  logic                 i_last;
  logic                 j_last;
  logic [AW-1:0]        addr;
  logic                 oversize_i;
  logic                 oversize_j;
  logic                 zero_size;
  logic [SW-1:0]        lat_i;
  logic [SW-1:0]        lat_j;

  // Row starts are tracked by the counters, so the input row strobe carries no information here.
  logic                 unused_in_i_enable;
  assign unused_in_i_enable = DATA_IN_I_ENABLE;

  assign i_last = (cnt_i == size_i - SW'(1));
  assign j_last = (cnt_j == size_j - SW'(1));
  assign addr   = AW'(cnt_i) * AW'(MAX_J) + AW'(cnt_j);

  assign oversize_i = (SIZE_I_IN > CONTROL_SIZE'(MAX_I));
  assign oversize_j = (SIZE_J_IN > CONTROL_SIZE'(MAX_J));
  assign zero_size  = (SIZE_I_IN == '0) || (SIZE_J_IN == '0);
  assign lat_i      = oversize_i ? SW'(MAX_I) : SW'(SIZE_I_IN);
  assign lat_j      = oversize_j ? SW'(MAX_J) : SW'(SIZE_J_IN);

  // Matrix buffer; contents survive reset on purpose.
  always_ff @(posedge CLK) begin
    if (!RST && state == LOAD && DATA_IN_J_ENABLE) begin
      mem[addr] <= DATA_IN;
    end
  end

`ifdef ACCELERATOR_TRANSPOSE_SIZE_CHECK_EN
  logic err_pend;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state             <= IDLE;
      READY             <= 1'b0;
      DATA_OUT_I_ENABLE <= 1'b0;
      DATA_OUT_J_ENABLE <= 1'b0;
      DATA_OUT          <= '0;
      size_i            <= '0;
      size_j            <= '0;
      cnt_i             <= '0;
      cnt_j             <= '0;
`ifdef ACCELERATOR_TRANSPOSE_SIZE_CHECK_EN
      ERROR             <= 1'b0;
      err_pend          <= 1'b0;
`endif
    end else begin
      READY <= 1'b0;
      case (state)
        // READY high means this is the completion cycle, where START must be ignored.
        IDLE: begin
          if (START && !READY) begin
            size_i <= lat_i;
            size_j <= lat_j;
            cnt_i  <= '0;
            cnt_j  <= '0;
`ifdef ACCELERATOR_TRANSPOSE_SIZE_CHECK_EN
            ERROR    <= 1'b0;
            err_pend <= oversize_i || oversize_j;
            if (zero_size || oversize_i || oversize_j) begin
              state <= DONE;
            end else begin
              state <= LOAD;
            end
`else
            if (zero_size) begin
              state <= DONE;
            end else begin
              state <= LOAD;
            end
`endif
          end
        end

        // Row-major fill: j inner, i outer.
        LOAD: begin
          if (DATA_IN_J_ENABLE) begin
            if (j_last) begin
              cnt_j <= '0;
              if (i_last) begin
                cnt_i <= '0;
                state <= EMIT;
              end else begin
                cnt_i <= cnt_i + SW'(1);
              end
            end else begin
              cnt_j <= cnt_j + SW'(1);
            end
          end
        end

        // Transposed drain: i inner, j outer, one element per cycle.
        EMIT: begin
          DATA_OUT          <= mem[addr];
          DATA_OUT_J_ENABLE <= 1'b1;
          DATA_OUT_I_ENABLE <= (cnt_i == '0);
          if (i_last) begin
            cnt_i <= '0;
            if (j_last) begin
              cnt_j <= '0;
              state <= DONE;
            end else begin
              cnt_j <= cnt_j + SW'(1);
            end
          end else begin
            cnt_i <= cnt_i + SW'(1);
          end
        end

        DONE: begin
          DATA_OUT_I_ENABLE <= 1'b0;
          DATA_OUT_J_ENABLE <= 1'b0;
          READY             <= 1'b1;
`ifdef ACCELERATOR_TRANSPOSE_SIZE_CHECK_EN
          ERROR             <= err_pend;
`endif
          state             <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_accelerator_standard_transformer_transpose.sv
// Directed/randomized bench for the transpose stage, checked against a queue-based transpose model.
module tb_accelerator_standard_transformer_transpose;

  logic        CLK;
  logic        RST;
  logic        START;
  logic        READY;
  logic [63:0] SIZE_I_IN;
  logic [63:0] SIZE_J_IN;
  logic        DATA_IN_I_ENABLE;
  logic        DATA_IN_J_ENABLE;
  logic [63:0] DATA_IN;
  logic        DATA_OUT_I_ENABLE;
  logic        DATA_OUT_J_ENABLE;
  logic [63:0] DATA_OUT;
`ifdef ACCELERATOR_TRANSPOSE_SIZE_CHECK_EN
  logic        ERROR;
`endif

  accelerator_standard_transformer_transpose #(
    .DATA_SIZE(64), .CONTROL_SIZE(64), .MAX_I(8), .MAX_J(8)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .START(START),
    .READY(READY),
    .SIZE_I_IN(SIZE_I_IN),
    .SIZE_J_IN(SIZE_J_IN),
    .DATA_IN_I_ENABLE(DATA_IN_I_ENABLE),
    .DATA_IN_J_ENABLE(DATA_IN_J_ENABLE),
    .DATA_IN(DATA_IN),
    .DATA_OUT_I_ENABLE(DATA_OUT_I_ENABLE),
    .DATA_OUT_J_ENABLE(DATA_OUT_J_ENABLE),
`ifdef ACCELERATOR_TRANSPOSE_SIZE_CHECK_EN
    .ERROR(ERROR),
`endif
    .DATA_OUT(DATA_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int          vectors = 0;
  int          errors  = 0;
  int          cyc     = 0;
  logic [63:0] last_dout_exp = '0;

  logic [63:0] od[$];
  bit          oi[$];
  int          oc[$];
  int          rc[$];
  bit          re[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and log every output beat and READY pulse with its cycle number.
  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
    if (DATA_OUT_J_ENABLE) begin
      od.push_back(DATA_OUT);
      oi.push_back(DATA_OUT_I_ENABLE);
      oc.push_back(cyc);
    end
    if (READY) begin
      rc.push_back(cyc);
`ifdef ACCELERATOR_TRANSPOSE_SIZE_CHECK_EN
      re.push_back(ERROR);
`else
      re.push_back(1'b0);
`endif
    end
  endtask

  task automatic do_xfer(input int si_in, input int sj_in, input int gap, input logic [63:0] base,
                         input bit noise, input bit start_at_ready, input int rst_emit, input string tag);
    int si, sj, n, s_cyc, last_acc, exp_n, exp_rdy, g, ii, jj;
    bit exp_err, rst_done;
    logic [63:0] mat[$];
    si = (si_in > 8) ? 8 : si_in;
    sj = (sj_in > 8) ? 8 : sj_in;
    exp_err = 1'b0;
    rst_done = 1'b0;
`ifdef ACCELERATOR_TRANSPOSE_SIZE_CHECK_EN
    exp_err = (si_in > 8) || (sj_in > 8);
    if (exp_err) si = 0;
`endif
    n = si * sj;
    od.delete(); oi.delete(); oc.delete(); rc.delete(); re.delete();
    for (int k = 0; k < n; k++) mat.push_back((base != 0) ? base + 64'(k) : {$urandom, $urandom});

    // START cycle; a data strobe here is outside LOAD and must be dropped.
    START = 1'b1;
    SIZE_I_IN = 64'(si_in);
    SIZE_J_IN = 64'(sj_in);
    DATA_IN_J_ENABLE = noise;
    DATA_IN = {$urandom, $urandom};
    step();
    s_cyc = cyc - 1;
    last_acc = s_cyc;
    START = 1'b0;
    DATA_IN_J_ENABLE = 1'b0;
`ifdef ACCELERATOR_TRANSPOSE_SIZE_CHECK_EN
    chk($sformatf("%s err_clr_on_start", tag), 64'(ERROR), 64'(0));
`endif

    for (int k = 0; k < n; k++) begin
      g = (gap < 0) ? $urandom_range(0, 2) : gap;
      for (int q = 0; q < g; q++) begin
        START = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        DATA_IN_J_ENABLE = 1'b0;
        step();
      end
      START = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      DATA_IN_J_ENABLE = 1'b1;
      DATA_IN_I_ENABLE = (k % sj == 0);
      DATA_IN = mat[k];
      step();
      last_acc = cyc - 1;
    end
    START = 1'b0;
    DATA_IN_J_ENABLE = 1'b0;
    DATA_IN_I_ENABLE = 1'b0;

    for (int b = 0; b < 400; b++) begin
      if (rc.size() != 0 || rst_done) break;
      if (noise) begin
        START = 1'($urandom_range(0, 1));
        SIZE_I_IN = 64'($urandom_range(0, 9));
        SIZE_J_IN = 64'($urandom_range(0, 9));
        DATA_IN_J_ENABLE = 1'($urandom_range(0, 1));
        DATA_IN = {$urandom, $urandom};
      end
      if (rst_emit > 0 && cyc == last_acc + rst_emit) RST = 1'b1;
      step();
      if (RST) begin
        RST = 1'b0;
        rst_done = 1'b1;
        chk($sformatf("%s rst_jen", tag), 64'(DATA_OUT_J_ENABLE), 64'(0));
        chk($sformatf("%s rst_ien", tag), 64'(DATA_OUT_I_ENABLE), 64'(0));
        chk($sformatf("%s rst_ready", tag), 64'(READY), 64'(0));
        chk($sformatf("%s rst_dout", tag), DATA_OUT, 64'(0));
      end
    end
    START = 1'b0;
    DATA_IN_J_ENABLE = 1'b0;

    exp_n = rst_done ? rst_emit - 1 : n;
    chk($sformatf("%s out_count", tag), 64'(od.size()), 64'(exp_n));
    for (int k = 0; k < exp_n && k < od.size(); k++) begin
      ii = k % si;
      jj = k / si;
      chk($sformatf("%s data[%0d]", tag, k), od[k], mat[ii * sj + jj]);
      chk($sformatf("%s ien[%0d]", tag, k), 64'(oi[k]), 64'(ii == 0));
      chk($sformatf("%s cyc[%0d]", tag, k), 64'(oc[k]), 64'(last_acc + 2 + k));
    end

    if (rst_done) begin
      last_dout_exp = '0;
      chk($sformatf("%s no_ready_after_rst", tag), 64'(rc.size()), 64'(0));
    end else begin
      exp_rdy = (n == 0) ? s_cyc + 2 : last_acc + 2 + n;
      chk($sformatf("%s ready_count", tag), 64'(rc.size()), 64'(1));
      if (rc.size() > 0) begin
        chk($sformatf("%s ready_cyc", tag), 64'(rc[0]), 64'(exp_rdy));
        chk($sformatf("%s ready_err", tag), 64'(re[0]), 64'(exp_err));
      end
      if (n > 0) last_dout_exp = mat[n - 1];
      chk($sformatf("%s dout_hold", tag), DATA_OUT, last_dout_exp);

      // The READY cycle itself: optionally try a zero-size START that must be ignored.
      START = start_at_ready;
      SIZE_I_IN = '0;
      SIZE_J_IN = '0;
      step();
      START = 1'b0;
      chk($sformatf("%s ready_pulse", tag), 64'(READY), 64'(0));
      if (start_at_ready) begin
        step();
        step();
        chk($sformatf("%s start_in_ready_ignored", tag), 64'(rc.size()), 64'(1));
      end
`ifdef ACCELERATOR_TRANSPOSE_SIZE_CHECK_EN
      chk($sformatf("%s err_hold", tag), 64'(ERROR), 64'(exp_err));
`endif
    end
  endtask

  initial begin
    RST = 1'b1;
    START = 1'b0;
    SIZE_I_IN = '0;
    SIZE_J_IN = '0;
    DATA_IN_I_ENABLE = 1'b0;
    DATA_IN_J_ENABLE = 1'b0;
    DATA_IN = '0;
    step();
    step();
    chk("reset ready", 64'(READY), 64'(0));
    chk("reset jen", 64'(DATA_OUT_J_ENABLE), 64'(0));
    chk("reset ien", 64'(DATA_OUT_I_ENABLE), 64'(0));
    chk("reset dout", DATA_OUT, 64'(0));
`ifdef ACCELERATOR_TRANSPOSE_SIZE_CHECK_EN
    chk("reset error", 64'(ERROR), 64'(0));
`endif
    RST = 1'b0;
    step();

    do_xfer(2, 3, 0, 64'd1, 1'b0, 1'b0, 0, "m2x3_b2b");
    do_xfer(2, 3, 2, 64'd1, 1'b0, 1'b0, 0, "m2x3_gap2");
    do_xfer(0, 4, 0, 64'd0, 1'b0, 1'b0, 0, "zero_i");
    do_xfer(3, 0, 0, 64'd0, 1'b0, 1'b1, 0, "zero_j_start_at_ready");
    do_xfer(3, 3, 0, 64'd0, 1'b0, 1'b0, 4, "m3x3_rst");
    do_xfer(1, 2, 0, 64'd7, 1'b0, 1'b0, 0, "m1x2_after_rst");
    do_xfer(2, 2, 1, 64'd0, 1'b1, 1'b0, 0, "m2x2_noise");
    do_xfer(9, 2, 0, 64'd0, 1'b0, 1'b0, 0, "oversize_i");
    do_xfer(2, 3, -1, 64'd0, 1'b0, 1'b1, 0, "after_oversize");
    do_xfer(8, 8, 0, 64'd0, 1'b0, 1'b0, 0, "m8x8");
    for (int r = 0; r < 6; r++) begin
      do_xfer($urandom_range(1, 8), $urandom_range(1, 8), -1, 64'd0, 1'(r % 2), 1'b0, 0,
              $sformatf("rand%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
